// File: rtl/mul_issue_sched.sv
// Round-robin issue scheduler sharing one multi-cycle multiplier FU among NREQ requesters.
// Optional watchdog enabled by defining MUL_SCHED_TIMEOUT_EN (err tied 0 otherwise).
module mul_issue_sched #(
  parameter int NREQ  = 2,
  parameter int LAT   = 7,
  parameter int TAG_W = 4,
  parameter int TMO   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*32-1:0]    req_a,
  input  logic [NREQ*32-1:0]    req_b,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic                  fu_en,
  output logic [31:0]           fu_a,
  output logic [31:0]           fu_b,
  input  logic                  fu_finish,
  input  logic [31:0]           fu_res,
  output logic [NREQ-1:0]       resp_valid,
  output logic [31:0]           resp_res,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  busy,
  output logic                  err
);
  // state  | meaning
  // SETTLE | flush out any op the un-reset FU may still hold, fu_finish ignored
  // IDLE   | arbitrate and issue in the same cycle
  // WAIT   | op in flight, result goes back to the winner
  // DRAIN  | op killed by flush, swallow its fu_finish

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SC_W  = $clog2(LAT + 2);

  if (NREQ < 2 || NREQ > 4 || TMO < 1) begin : g_param_check
    $error("mul_issue_sched: unsupported parameter values");
  end

  typedef enum logic [1:0] {S_SETTLE, S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [SC_W-1:0]   settle_cnt;
  logic [IDX_W-1:0]  rr_ptr, grant_idx, winner;
  logic [TAG_W-1:0]  tag_q;
  logic              grant, deliver, timeout;

  // Scan downwards so the last hit is the nearest requester after rr_ptr.
  always_comb begin
    grant_idx = rr_ptr;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IDX_W'((int'(rr_ptr) + k) % NREQ)])
        grant_idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
    end
  end

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    deliver   = 1'b0;
    req_ready = '0;
    fu_en     = 1'b0;
    fu_a      = '0;
    fu_b      = '0;
    case (state)
      S_SETTLE: if (settle_cnt == SC_W'(1)) state_nx = S_IDLE;
      S_IDLE: begin
        if (|req_valid && !flush) begin
          grant                = 1'b1;
          req_ready[grant_idx] = 1'b1;
          fu_en                = 1'b1;
          fu_a                 = req_a[32*grant_idx +: 32];
          fu_b                 = req_b[32*grant_idx +: 32];
          state_nx             = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fu_finish) begin
          deliver  = !flush;
          state_nx = S_IDLE;
        end else if (timeout) begin
          state_nx = S_SETTLE;
        end else if (flush) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fu_finish)    state_nx = S_IDLE;
        else if (timeout) state_nx = S_SETTLE;
      end
      default: state_nx = S_SETTLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_SETTLE;
      settle_cnt <= SC_W'(LAT + 1);
      rr_ptr     <= '0;
      winner     <= '0;
      tag_q      <= '0;
      resp_valid <= '0;
      resp_res   <= '0;
      resp_tag   <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= '0;
      if (state_nx == S_SETTLE && state != S_SETTLE)
        settle_cnt <= SC_W'(LAT + 1);
      else if (state == S_SETTLE)
        settle_cnt <= settle_cnt - 1'b1;
      if (grant) begin
        rr_ptr <= grant_idx;
        winner <= grant_idx;
        tag_q  <= req_tag[TAG_W*grant_idx +: TAG_W];
      end
      if (deliver) begin
        resp_valid <= NREQ'(1) << winner;
        resp_res   <= fu_res;
        resp_tag   <= tag_q;
      end
    end
  end

`ifdef MUL_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // cnt runs from issue through WAIT and DRAIN; TMO-1 marks the last allowed cycle.
  assign timeout = (state == S_WAIT || state == S_DRAIN) && !fu_finish &&
                   (cnt == CNT_W'(TMO - 1));
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant)
        cnt <= '0;
      else if (state == S_WAIT || state == S_DRAIN)
        cnt <= cnt + 1'b1;
      if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issue_sched.sv
// Scoreboard bench for mul_issue_sched: directed requests, behavioural FU with fixed latency.
// Covers the watchdog path only when MUL_SCHED_TIMEOUT_EN is defined.
module tb_mul_issue_sched;
  localparam int NREQ  = 2;
  localparam int LAT   = 7;
  localparam int TAG_W = 4;
  localparam int TMO   = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*32-1:0]    req_a, req_b;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [NREQ-1:0]       req_ready;
  logic                  flush;
  logic                  fu_en;
  logic [31:0]           fu_a, fu_b;
  logic                  fu_finish = 1'b0;
  logic [31:0]           fu_res = '0;
  logic [NREQ-1:0]       resp_valid;
  logic [31:0]           resp_res;
  logic [TAG_W-1:0]      resp_tag;
  logic                  busy, err;

  mul_issue_sched #(.NREQ(NREQ), .LAT(LAT), .TAG_W(TAG_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .req_ready(req_ready), .flush(flush), .fu_en(fu_en),
    .fu_a(fu_a), .fu_b(fu_b), .fu_finish(fu_finish), .fu_res(fu_res),
    .resp_valid(resp_valid), .resp_res(resp_res), .resp_tag(resp_tag),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Behavioural FU: result appears LAT cycles after the fu_en cycle.
  int          cyc = 0;
  bit          fu_pend = 0;
  bit          fu_hang = 0;
  int          fin_at = 0;
  logic [31:0] prod = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    fu_finish = fu_pend && (cyc == fin_at);
    if (fu_finish) fu_pend = 0;
    fu_res = fu_finish ? prod : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (fu_en && !fu_hang) begin
      fu_pend = 1;
      fin_at  = cyc + LAT;
      prod    = fu_a * fu_b;
    end
  end

  typedef struct {
    logic [NREQ-1:0]  oh;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (req_ready != '0) check("ready_only_idle", busy, 0);
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", resp_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_valid", resp_valid, mon_e.oh);
        check("resp_res", resp_res, mon_e.res);
        check("resp_tag", resp_tag, mon_e.tag);
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input logic [NREQ-1:0] oh, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [TAG_W-1:0] tag, input bit push,
                       output int gcyc);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while ((req_valid & req_ready) == '0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 60) begin
      check("grant_timeout", 0, 1);
      gcyc = -1000;
    end else begin
      gcyc = cyc;
      check("grant_onehot", req_ready, oh);
      check("fu_en", fu_en, 1);
      check("fu_a", fu_a, a);
      check("fu_b", fu_b, b);
      if (push) begin
        e.oh  = oh;
        e.res = res;
        e.tag = tag;
        e.cyc = gcyc + LAT + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rel, g0, g1, g2, g3, g4, g5, g6;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 2'b01;
    req_a     = {32'd0, 32'd6};
    req_b     = {32'd0, 32'd7};
    req_tag   = {4'd0, 4'd3};

    // reset values
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", req_ready, 0);
    check("rst_fu_en", fu_en, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_res", resp_res, 0);
    check("rst_resp_tag", resp_tag, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;

    // settle window of LAT+1 cycles, then 6*7 for requester 0
    issue(2'b01, 32'd6, 32'd7, 32'd42, 4'd3, 1, g0);
    check("settle_len", g0 - rel, LAT + 1);
    req_valid = 2'b00;

    // both requesters held: alternating grants, back-to-back every LAT+1 cycles
    req_a     = {32'hFFFF_FFFE, 32'hFFFF_FFFE};
    req_b     = {32'd2, 32'd2};
    req_tag   = {4'd1, 4'd2};
    req_valid = 2'b11;
    issue(2'b10, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC, 4'd1, 1, g1);
    check("first_after_resp", g1 - g0, LAT + 1);
    issue(2'b01, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC, 4'd2, 1, g2);
    check("b2b_period_a", g2 - g1, LAT + 1);
    issue(2'b10, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC, 4'd1, 1, g1);
    check("b2b_period_b", g1 - g2, LAT + 1);
    issue(2'b01, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC, 4'd2, 1, g2);
    req_valid = 2'b00;

    // flush 3 cycles after issue: killed op drains, next grant right after fu_finish
    req_a     = {32'd4, 32'd3};
    req_b     = {32'd4, 32'd5};
    req_tag   = {4'd6, 4'd5};
    req_valid = 2'b01;
    issue(2'b01, 32'd3, 32'd5, 32'd15, 4'd5, 0, g3);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 2'b10;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_busy", busy, 1);
    end
    issue(2'b10, 32'd4, 32'd4, 32'd16, 4'd6, 1, g4);
    check("grant_after_drain", g4 - g3, LAT + 1);
    req_valid = 2'b00;

    // flush coincident with fu_finish: no response, grant in the following cycle
    req_a     = {32'd10, 32'd9};
    req_b     = {32'd3, 32'd9};
    req_tag   = {4'd8, 4'd7};
    req_valid = 2'b01;
    issue(2'b01, 32'd9, 32'd9, 32'd81, 4'd7, 0, g5);
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 2'b10;
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue(2'b10, 32'd10, 32'd3, 32'd30, 4'd8, 1, g6);
    check("grant_after_flush_finish", g6 - g5, LAT + 1);
    req_valid = 2'b00;

`ifdef MUL_SCHED_TIMEOUT_EN
    // FU never answers: watchdog fires after TMO WAIT cycles and re-enters SETTLE
    fu_hang   = 1;
    req_a     = {32'd0, 32'd1};
    req_b     = {32'd0, 32'd1};
    req_tag   = {4'd0, 4'd9};
    req_valid = 2'b01;
    issue(2'b01, 32'd1, 32'd1, 32'd1, 4'd9, 0, g5);
    req_valid = 2'b00;
    repeat (TMO) @(negedge clk);
    check("wdog_not_yet", err, 0);
    @(negedge clk);
    check("wdog_err", err, 1);
    check("wdog_busy", busy, 1);
    repeat (LAT + 2) @(negedge clk);
    check("wdog_idle", busy, 0);
    check("wdog_err_sticky", err, 1);
    fu_hang = 0;
`else
    check("err_tied", err, 0);
`endif

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
